// File: rtl/lp_seq_pkg.sv
// Shared encodings for the lp pass-counter sequencer: FSM states and counter preload values.
package lp_seq_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_F2   = 3'd1;
  localparam logic [2:0] ST_F4   = 3'd2;
  localparam logic [2:0] ST_F8   = 3'd3;
  localparam logic [2:0] ST_F7   = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    F2   = ST_F2,
    F4   = ST_F4,
    F8   = ST_F8,
    F7   = ST_F7
  } state_e;

  localparam logic [1:0] LP_A = 2'b01;
  localparam logic [1:0] LP_B = 2'b10;
  localparam logic [1:0] LP_Z = 2'b00;

endpackage

// File: rtl/lp_seq_pass_cnt.sv
// 2-bit pass counter with prioritised increment/preload/clear controls and value decodes.
module pass_cnt
  import lp_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       set_a_i,
  input  logic       set_b_i,
  input  logic       clr_i,
  output logic [1:0] cnt_o,
  output logic       lp_o,
  output logic       lp1_o,
  output logic       lp2_o,
  output logic       lp3_o
);

  logic [1:0] cnt_d;
  logic [1:0] cnt_q;

  // next counter value: increment wins, then the two preloads, then clear
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = cnt_q + 2'd1;
    end else if (set_a_i) begin
      cnt_d = LP_A;
    end else if (set_b_i) begin
      cnt_d = LP_B;
    end else if (clr_i) begin
      cnt_d = LP_Z;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= LP_Z;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign lp_o  = (cnt_q != 2'b00);
  assign lp1_o = (cnt_q == 2'b01);
  assign lp2_o = (cnt_q == 2'b10);
  assign lp3_o = (cnt_q == 2'b11);

endmodule

// File: rtl/lp_seq.sv
// Multi-word memory operation sequencer: preloads the pass counter from the instruction
// flags, runs one req/ack handshake per word and finishes when the counter wraps to 00.
module lp_seq
  import lp_seq_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       start,
  input  logic       mw,
  input  logic       dw,
  input  logic       fwz,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic [0:1] out,
  output logic       lp,
  output logic       lp1,
  output logic       lp2,
  output logic       lp3,
  output logic       busy,
  output logic       f2,
  output logic       f4,
  output logic       done
);

  state_e     state_q;
  logic       inc_s;
  logic       set_a_s;
  logic       set_b_s;
  logic       clr_s;
  logic [1:0] cnt_s;

  // counter controls; the preload lands on the same edge that leaves IDLE
  always_comb begin
    inc_s   = 1'b0;
    set_a_s = 1'b0;
    set_b_s = 1'b0;
    clr_s   = 1'b0;
    case (state_q)
      IDLE: begin
        set_a_s = start & ~mw;
        set_b_s = start & mw;
      end
      F2: begin
        set_b_s = ~mw & dw;
        clr_s   = mw & fwz;
      end
      F4: begin
        inc_s = mem_ack;
      end
      F7: begin
        clr_s = 1'b1;
      end
      default: begin
        inc_s = 1'b0;
      end
    endcase
  end

  // sequencer state; F8 sees the already-incremented counter to detect the wrap
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_q <= F2;
        F2:      state_q <= (mw & fwz) ? F7 : F4;
        F4:      if (mem_ack) state_q <= F8;
        F8:      state_q <= (cnt_s == LP_Z) ? F7 : F4;
        F7:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  pass_cnt u_pass_cnt (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .inc_i   (inc_s),
    .set_a_i (set_a_s),
    .set_b_i (set_b_s),
    .clr_i   (clr_s),
    .cnt_o   (cnt_s),
    .lp_o    (lp),
    .lp1_o   (lp1),
    .lp2_o   (lp2),
    .lp3_o   (lp3)
  );

  assign out     = cnt_s;
  assign mem_req = (state_q == F4);
  assign busy    = (state_q != IDLE);
  assign f2      = (state_q == F2);
  assign f4      = (state_q == F4);
  assign done    = (state_q == F7);

endmodule

// File: tb/tb_lp_seq.sv
// Directed self-checking bench for lp_seq with hand-computed per-cycle expectations.
module tb_lp_seq;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       start;
  logic       mw;
  logic       dw;
  logic       fwz;
  logic       mem_ack;
  logic       mem_req;
  logic [1:0] out;
  logic       lp;
  logic       lp1;
  logic       lp2;
  logic       lp3;
  logic       busy;
  logic       f2;
  logic       f4;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  lp_seq dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .start   (start),
    .mw      (mw),
    .dw      (dw),
    .fwz     (fwz),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .out     (out),
    .lp      (lp),
    .lp1     (lp1),
    .lp2     (lp2),
    .lp3     (lp3),
    .busy    (busy),
    .f2      (f2),
    .f4      (f4),
    .done    (done)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic [1:0] e_out, input logic e_req,
                            input logic e_done, input logic e_busy);
    check_eq({tag, ".out"},  {6'd0, out},     {6'd0, e_out});
    check_eq({tag, ".req"},  {7'd0, mem_req}, {7'd0, e_req});
    check_eq({tag, ".done"}, {7'd0, done},    {7'd0, e_done});
    check_eq({tag, ".busy"}, {7'd0, busy},    {7'd0, e_busy});
  endtask

  task automatic launch(input logic m, input logic d, input logic z);
    mw = m; dw = d; fwz = z; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [1:0] exp_before [3];
  logic [1:0] exp_after  [3];

  initial begin
    reset = 1'b1; start = 1'b0; mw = 1'b0; dw = 1'b0; fwz = 1'b0; mem_ack = 1'b0;
    exp_before[0] = 2'b01; exp_before[1] = 2'b10; exp_before[2] = 2'b11;
    exp_after[0]  = 2'b10; exp_after[1]  = 2'b11; exp_after[2]  = 2'b00;
    tick();
    tick();
    expect_cyc("rst", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    expect_cyc("idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a handshake
    launch(1'b0, 1'b0, 1'b0);
    tick();
    expect_cyc("mid.f4", 2'b01, 1'b1, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    expect_cyc("mid.rst", 2'b00, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    mem_ack = 1'b1;
    tick();
    expect_cyc("mid.lateack", 2'b00, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b0;

    // mw=1 fwz=0 with ack held high: two words, done at n+6
    mem_ack = 1'b1;
    launch(1'b1, 1'b0, 1'b0);
    check_eq("mw.f2flag", {7'd0, f2}, 8'd1);
    expect_cyc("mw.f2",  2'b10, 1'b0, 1'b0, 1'b1);
    tick(); expect_cyc("mw.f4a", 2'b10, 1'b1, 1'b0, 1'b1);
    tick(); expect_cyc("mw.f8a", 2'b11, 1'b0, 1'b0, 1'b1);
    check_eq("mw.lp3", {7'd0, lp3}, 8'd1);
    tick(); expect_cyc("mw.f4b", 2'b11, 1'b1, 1'b0, 1'b1);
    tick(); expect_cyc("mw.f8b", 2'b00, 1'b0, 1'b0, 1'b1);
    tick(); expect_cyc("mw.f7",  2'b00, 1'b0, 1'b1, 1'b1);
    tick(); expect_cyc("mw.idle", 2'b00, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b0;

    // mw=0 dw=0: three words, each ack arriving in the 4th F4 cycle
    launch(1'b0, 1'b0, 1'b0);
    expect_cyc("w3.f2", 2'b01, 1'b0, 1'b0, 1'b1);
    tick();
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 4; c++) begin
        expect_cyc($sformatf("w3.f4.%0d.%0d", w, c), exp_before[w], 1'b1, 1'b0, 1'b1);
        check_eq($sformatf("w3.lp1.%0d.%0d", w, c), {7'd0, lp1}, {7'd0, (w == 0)});
        if (c == 3) mem_ack = 1'b1;
        tick();
      end
      mem_ack = 1'b0;
      expect_cyc($sformatf("w3.f8.%0d", w), exp_after[w], 1'b0, 1'b0, 1'b1);
      tick();
    end
    expect_cyc("w3.f7", 2'b00, 1'b0, 1'b1, 1'b1);
    tick();
    expect_cyc("w3.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // mw=1 fwz=1: zero words, done at n+2
    launch(1'b1, 1'b0, 1'b1);
    check_eq("z.f2flag", {7'd0, f2}, 8'd1);
    check_eq("z.req0", {7'd0, mem_req}, 8'd0);
    tick(); expect_cyc("z.f7", 2'b00, 1'b0, 1'b1, 1'b1);
    tick(); expect_cyc("z.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // mw=0 dw=1: preload 01, forced to 10 in F2, two words
    launch(1'b0, 1'b1, 1'b0);
    expect_cyc("dw.f2", 2'b01, 1'b0, 1'b0, 1'b1);
    mem_ack = 1'b1;
    tick(); expect_cyc("dw.f4a", 2'b10, 1'b1, 1'b0, 1'b1);
    check_eq("dw.lp2", {7'd0, lp2}, 8'd1);
    tick(); expect_cyc("dw.f8a", 2'b11, 1'b0, 1'b0, 1'b1);
    tick(); expect_cyc("dw.f4b", 2'b11, 1'b1, 1'b0, 1'b1);
    tick(); expect_cyc("dw.f8b", 2'b00, 1'b0, 1'b0, 1'b1);
    tick(); expect_cyc("dw.f7",  2'b00, 1'b0, 1'b1, 1'b1);
    mem_ack = 1'b0;
    tick(); expect_cyc("dw.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // start while busy and ack in F8 are both ignored
    launch(1'b1, 1'b0, 1'b0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_cyc("ign.f4", 2'b10, 1'b1, 1'b0, 1'b1);
    check_eq("ign.f4flag", {7'd0, f4}, 8'd1);
    mem_ack = 1'b1;
    tick(); expect_cyc("ign.f8", 2'b11, 1'b0, 1'b0, 1'b1);
    tick(); expect_cyc("ign.f4b", 2'b11, 1'b1, 1'b0, 1'b1);
    mem_ack = 1'b0;
    tick(); expect_cyc("ign.hold", 2'b11, 1'b1, 1'b0, 1'b1);
    mem_ack = 1'b1;
    tick(); expect_cyc("ign.f8b", 2'b00, 1'b0, 1'b0, 1'b1);
    mem_ack = 1'b0;
    tick(); expect_cyc("ign.f7", 2'b00, 1'b0, 1'b1, 1'b1);
    tick(); expect_cyc("ign.idle", 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    expect_cyc("ign.noq", 2'b00, 1'b0, 1'b0, 1'b0);
    check_eq("ign.lp", {7'd0, lp}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
